// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed 7-segment scanner with a double-buffered valid/ready load port and PWM brightness.
// Optional build macro SEG7_LZ_BLANK_EN blanks leading zeros (digit 0 is never blanked).
module seg7_scan_ctrl #(
  parameter int NDIG        = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int REFRESH_HZ  = 60,
  parameter int REFRESH_DIV = CLK_HZ / (REFRESH_HZ * NDIG),
  parameter int BW          = 2,
  parameter int HEX         = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] digits_in,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [BW-1:0]     brightness,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   dig_en,
  output logic              frame_done
);

  localparam int STEP = REFRESH_DIV >> BW;
  localparam int TW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW   = $clog2(NDIG);
  localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'b1111110;
      4'h1: r = 7'b0110000;
      4'h2: r = 7'b1101101;
      4'h3: r = 7'b1111001;
      4'h4: r = 7'b0110011;
      4'h5: r = 7'b1011011;
      4'h6: r = 7'b1011111;
      4'h7: r = 7'b1110000;
      4'h8: r = 7'b1111111;
      4'h9: r = 7'b1111011;
      4'hA: r = 7'b1110111;
      4'hB: r = 7'b0011111;
      4'hC: r = 7'b1001110;
      4'hD: r = 7'b0111101;
      4'hE: r = 7'b1001111;
      default: r = 7'b1000111;
    endcase
    if (HEX == 0 && n > 4'd9) r = 7'b0000000;
    return r;
  endfunction

  logic [TW-1:0]     r_tick;
  logic [IW-1:0]     r_idx;
  logic [4*NDIG-1:0] r_active;
  logic [NDIG-1:0]   r_active_dp;
  logic [4*NDIG-1:0] r_shadow;
  logic [NDIG-1:0]   r_shadow_dp;
  logic              r_pending;
  logic [BW-1:0]     r_duty;
  logic [6:0]        r_seg;
  logic              r_dp;
  logic [NDIG-1:0]   r_dig_en;
  logic              r_frame_done;

  logic              w_tick_last;
  logic              w_wrap;
  logic              w_load;
  logic [BW-1:0]     w_duty;
  logic [TW:0]       w_thresh;
  logic              w_on;
  logic [3:0]        w_nib [NDIG];
  logic [6:0]        w_seg_next;

  assign w_tick_last = (r_tick == TICK_LAST);
  assign w_wrap      = w_tick_last && (r_idx == IDX_LAST);
  assign w_load      = load_valid && !r_pending;
  assign load_ready  = !r_pending && !rst;

  // Duty is sampled from the input on the first tick of a slot and held for the rest of it.
  assign w_duty   = (r_tick == '0) ? brightness : r_duty;
  assign w_thresh = (TW+1)'((int'(w_duty) + 1) * STEP);
  assign w_on     = ({1'b0, r_tick} < w_thresh);

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_nib
      assign w_nib[gi] = r_active[4*gi +: 4];
    end
  endgenerate

`ifdef SEG7_LZ_BLANK_EN
  // w_lz[i]: every nibble from the top digit down to i is zero.
  logic w_lz [NDIG];
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_lz
      if (gi == 0) begin : g_first
        assign w_lz[gi] = 1'b0;
      end else if (gi == NDIG - 1) begin : g_top
        assign w_lz[gi] = (w_nib[gi] == 4'h0);
      end else begin : g_mid
        assign w_lz[gi] = w_lz[gi+1] && (w_nib[gi] == 4'h0);
      end
    end
  endgenerate
  assign w_seg_next = w_lz[r_idx] ? 7'b0000000 : decode(w_nib[r_idx]);
`else
  assign w_seg_next = decode(w_nib[r_idx]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick       <= '0;
      r_idx        <= '0;
      r_active     <= '0;
      r_active_dp  <= '0;
      r_shadow     <= '0;
      r_shadow_dp  <= '0;
      r_pending    <= 1'b0;
      r_duty       <= '0;
      r_seg        <= '0;
      r_dp         <= 1'b0;
      r_dig_en     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_tick <= w_tick_last ? '0 : r_tick + TW'(1);
      if (w_tick_last) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      r_duty <= w_duty;
      // A load and a commit never coincide: a load needs pending=0, a commit needs pending=1.
      if (w_load) begin
        r_shadow    <= digits_in;
        r_shadow_dp <= dp_in;
        r_pending   <= 1'b1;
      end else if (w_wrap && r_pending) begin
        r_active    <= r_shadow;
        r_active_dp <= r_shadow_dp;
        r_pending   <= 1'b0;
      end
      r_seg        <= w_seg_next;
      r_dp         <= r_active_dp[r_idx];
      r_dig_en     <= w_on ? (NDIG'(1) << r_idx) : '0;
      r_frame_done <= w_wrap;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign dig_en     = r_dig_en;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (NDIG=4, REFRESH_DIV=16, BW=2, HEX=1); honours SEG7_LZ_BLANK_EN.
module tb_seg7_scan_ctrl;

  localparam int NDIG = 4;
  localparam int BW   = 2;
`ifdef SEG7_LZ_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'b0000000;
`else
  localparam logic [6:0] LZ_SEG = 7'b1111110;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [4*NDIG-1:0] digits_in;
  logic [NDIG-1:0]   dp_in;
  logic              load_valid;
  logic              load_ready;
  logic [BW-1:0]     brightness;
  logic [6:0]        seg;
  logic              dp;
  logic [NDIG-1:0]   dig_en;
  logic              frame_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NDIG(NDIG), .CLK_HZ(50_000_000), .REFRESH_HZ(60),
    .REFRESH_DIV(16), .BW(BW), .HEX(1)
  ) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
    .load_valid(load_valid), .load_ready(load_ready), .brightness(brightness),
    .seg(seg), .dp(dp), .dig_en(dig_en), .frame_done(frame_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (load_ready !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    n_cmp++;
    if (load_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ready_timeout: load_ready=%b required 1", tag, load_ready);
    end
  endtask

  task automatic wait_frame(input string tag);
    int k = 0;
    step();
    while (frame_done !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL %s_frame_timeout: frame_done=%b required 1", tag, frame_done);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input string tag);
    digits_in  = d;
    dp_in      = p;
    load_valid = 1'b1;
    wait_ready(tag);
    step();
    load_valid = 1'b0;
    $display("load %s: digits=%h dp=%b accepted at %0t", tag, d, p, $time);
  endtask

  // Commit lands on the boundary: ready rises in the same cycle frame_done pulses.
  task automatic wait_commit(input string tag);
    wait_ready(tag);
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL %s_commit_boundary: frame_done=%b required 1", tag, frame_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load_valid = 1'b0; digits_in = '0; dp_in = '0; brightness = 2'd3;
    run(3);
    n_cmp++; if (seg !== 7'b0) begin n_err++; $display("FAIL rst_seg: got %b required 0000000", seg); end
    n_cmp++; if (dp !== 1'b0) begin n_err++; $display("FAIL rst_dp: got %b required 0", dp); end
    n_cmp++; if (dig_en !== 4'b0) begin n_err++; $display("FAIL rst_dig_en: got %b required 0000", dig_en); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done: got %b required 0", frame_done); end
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b required 0", load_ready); end
    rst = 1'b0;
    step();
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b required 1", load_ready); end
    n_cmp++; if (dig_en !== 4'b0001) begin n_err++; $display("FAIL rst_first_slot_en: got %b required 0001", dig_en); end
    n_cmp++; if (seg !== 7'b1111110) begin n_err++; $display("FAIL rst_first_slot_seg: got %b required 1111110", seg); end
    $display("reset sequence done at %0t", $time);
  endtask

  task automatic test_basic();
    brightness = 2'd3;
    do_load(16'h1234, 4'b0000, "basic");
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL basic_pending: ready=%b required 0", load_ready); end
    wait_commit("basic");
    step();
    n_cmp++; if (dig_en !== 4'b0001) begin n_err++; $display("FAIL basic_s0_en: got %b required 0001", dig_en); end
    n_cmp++; if (seg !== 7'b0110011) begin n_err++; $display("FAIL basic_s0_seg: got %b required 0110011", seg); end
    n_cmp++; if (dp !== 1'b0) begin n_err++; $display("FAIL basic_s0_dp: got %b required 0", dp); end
    run(15);
    n_cmp++; if (dig_en !== 4'b0001) begin n_err++; $display("FAIL basic_s0_end_en: got %b required 0001", dig_en); end
    run(1);
    n_cmp++; if (dig_en !== 4'b0010) begin n_err++; $display("FAIL basic_s1_en: got %b required 0010", dig_en); end
    n_cmp++; if (seg !== 7'b1111001) begin n_err++; $display("FAIL basic_s1_seg: got %b required 1111001", seg); end
    run(32);
    n_cmp++; if (dig_en !== 4'b1000) begin n_err++; $display("FAIL basic_s3_en: got %b required 1000", dig_en); end
    n_cmp++; if (seg !== 7'b0110000) begin n_err++; $display("FAIL basic_s3_seg: got %b required 0110000", seg); end
    run(14);
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL basic_fd_early: got %b required 0", frame_done); end
    run(1);
    n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL basic_fd_period64: got %b required 1", frame_done); end
    n_cmp++; if (dig_en !== 4'b1000) begin n_err++; $display("FAIL basic_fd_last_slot: got %b required 1000", dig_en); end
  endtask

  task automatic test_back_to_back();
    do_load(16'h1111, 4'b0000, "b2b_first");
    digits_in  = 16'h2222;
    load_valid = 1'b1;
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL b2b_blocked: ready=%b required 0", load_ready); end
    wait_commit("b2b_first");
    step();
    $display("load b2b_second: digits=2222 accepted at %0t", $time);
    load_valid = 1'b0;
    n_cmp++; if (seg !== 7'b0110000) begin n_err++; $display("FAIL b2b_s0_old: got %b required 0110000", seg); end
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_pending: ready=%b required 0", load_ready); end
    run(48);
    n_cmp++; if (seg !== 7'b0110000) begin n_err++; $display("FAIL b2b_s3_no_mix: got %b required 0110000", seg); end
    wait_commit("b2b_second");
    step();
    n_cmp++; if (seg !== 7'b1101101) begin n_err++; $display("FAIL b2b_s0_new: got %b required 1101101", seg); end
    n_cmp++; if (dig_en !== 4'b0001) begin n_err++; $display("FAIL b2b_s0_new_en: got %b required 0001", dig_en); end
  endtask

  task automatic test_brightness();
    int c;
    wait_frame("bright");
    brightness = 2'd0; c = 0;
    for (int i = 0; i < 16; i++) begin step(); if (dig_en != 4'b0) c++; end
    n_cmp++; if (c != 4) begin n_err++; $display("FAIL bright0_on: got %0d cycles required 4", c); end
    brightness = 2'd2; c = 0;
    for (int i = 0; i < 16; i++) begin step(); if (dig_en != 4'b0) c++; end
    n_cmp++; if (c != 12) begin n_err++; $display("FAIL bright2_on: got %0d cycles required 12", c); end
    brightness = 2'd0; c = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) brightness = 2'd3;
      step();
      if (dig_en != 4'b0) c++;
    end
    n_cmp++; if (c != 4) begin n_err++; $display("FAIL bright_midslot_held: got %0d cycles required 4", c); end
    c = 0;
    for (int i = 0; i < 16; i++) begin step(); if (dig_en != 4'b0) c++; end
    n_cmp++; if (c != 16) begin n_err++; $display("FAIL bright3_on: got %0d cycles required 16", c); end
    $display("brightness sweep done at %0t", $time);
  endtask

  task automatic test_lz();
    do_load(16'h0050, 4'b0000, "lz");
    wait_commit("lz");
    step();
    n_cmp++; if (seg !== 7'b1111110) begin n_err++; $display("FAIL lz_s0: got %b required 1111110", seg); end
    run(16);
    n_cmp++; if (seg !== 7'b1011011) begin n_err++; $display("FAIL lz_s1: got %b required 1011011", seg); end
    run(16);
    n_cmp++; if (seg !== LZ_SEG) begin n_err++; $display("FAIL lz_s2: got %b required %b", seg, LZ_SEG); end
    n_cmp++; if (dig_en !== 4'b0100) begin n_err++; $display("FAIL lz_s2_en: got %b required 0100", dig_en); end
    run(16);
    n_cmp++; if (seg !== LZ_SEG) begin n_err++; $display("FAIL lz_s3: got %b required %b", seg, LZ_SEG); end
  endtask

  task automatic test_hex_dp();
    do_load(16'h00A0, 4'b0100, "hexdp");
    wait_commit("hexdp");
    step();
    n_cmp++; if (dp !== 1'b0) begin n_err++; $display("FAIL hexdp_s0_dp: got %b required 0", dp); end
    run(16);
    n_cmp++; if (seg !== 7'b1110111) begin n_err++; $display("FAIL hexdp_s1_A: got %b required 1110111", seg); end
    n_cmp++; if (dp !== 1'b0) begin n_err++; $display("FAIL hexdp_s1_dp: got %b required 0", dp); end
    run(16);
    n_cmp++; if (dp !== 1'b1) begin n_err++; $display("FAIL hexdp_s2_dp: got %b required 1", dp); end
    n_cmp++; if (seg !== LZ_SEG) begin n_err++; $display("FAIL hexdp_s2_seg: got %b required %b", seg, LZ_SEG); end
    run(16);
    n_cmp++; if (dp !== 1'b0) begin n_err++; $display("FAIL hexdp_s3_dp: got %b required 0", dp); end
  endtask

  task automatic test_reset_mid();
    do_load(16'h8888, 4'b1111, "drop");
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL mid_pending: ready=%b required 0", load_ready); end
    run(5);
    rst = 1'b1;
    step();
    n_cmp++; if (seg !== 7'b0) begin n_err++; $display("FAIL mid_rst_seg: got %b required 0000000", seg); end
    n_cmp++; if (dp !== 1'b0) begin n_err++; $display("FAIL mid_rst_dp: got %b required 0", dp); end
    n_cmp++; if (dig_en !== 4'b0) begin n_err++; $display("FAIL mid_rst_en: got %b required 0000", dig_en); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL mid_rst_fd: got %b required 0", frame_done); end
    rst = 1'b0;
    step();
    n_cmp++; if (dig_en !== 4'b0001) begin n_err++; $display("FAIL mid_idx0: got %b required 0001", dig_en); end
    n_cmp++; if (seg !== 7'b1111110) begin n_err++; $display("FAIL mid_zero: got %b required 1111110", seg); end
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b required 1", load_ready); end
    wait_frame("mid");
    step();
    n_cmp++; if (seg !== 7'b1111110) begin n_err++; $display("FAIL mid_dropped_s0: got %b required 1111110", seg); end
    n_cmp++; if (dp !== 1'b0) begin n_err++; $display("FAIL mid_dropped_dp: got %b required 0", dp); end
    run(16);
    n_cmp++; if (seg !== 7'b1111110) begin n_err++; $display("FAIL mid_dropped_s1: got %b required 1111110", seg); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_brightness();
    test_lz();
    test_hex_dp();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
